// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared store-splice size codes and lane helper for the data-memory responder
package dmem_responder_pkg;

    localparam logic [1:0] SPL_SB = 2'd0;
    localparam logic [1:0] SPL_SH = 2'd1;
    localparam logic [1:0] SPL_SW = 2'd2;
    localparam logic [1:0] SPL_SD = 2'd3;

    // First byte lane touched by an access; misaligned low bits are dropped.
    function automatic logic [2:0] spl_lane(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SPL_SD:  return 3'd0;
            SPL_SW:  return {off[2], 2'b00};
            SPL_SH:  return {off[2:1], 1'b0};
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_mask.sv
// rtl/dmem_byte_mask.sv - size + offset to byte enables and misalignment flag (DMEM_MISALIGN_CHECK_EN)
module dmem_byte_mask
    import dmem_responder_pkg::*;
(
    input  logic [1:0] size,
    input  logic [2:0] offset,
    output logic [7:0] byte_en,
    output logic       misalign
);

    logic [2:0] lane;

    always_comb begin
        lane     = spl_lane(size, offset);
        byte_en  = 8'h00;
        misalign = 1'b0;
        case (size)
            SPL_SD:  byte_en = 8'hFF;
            SPL_SW:  byte_en = 8'h0F << lane;
            SPL_SH:  byte_en = 8'h03 << lane;
            default: byte_en = 8'h01 << lane;
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        case (size)
            SPL_SD:  misalign = |offset;
            SPL_SW:  misalign = |offset[1:0];
            SPL_SH:  misalign = offset[0];
            default: misalign = 1'b0;
        endcase
`else
        misalign = 1'b0;
`endif
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed wait states (DMEM_MISALIGN_CHECK_EN)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int BE_W = 8;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESPOND} state_t;

    typedef struct packed {
        logic            write;
        logic            err;
        logic [BE_W-1:0] be;
        logic [63:0]     data;
        logic [AW-1:0]   idx;
    } cmd_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    cmd_t            cmd_q, cmd_d, cmd_in, cmd_sel;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [63:0]     rsp_rdata_q, rsp_rdata_d;
    logic            go_rsp;
    logic [BE_W-1:0] be;
    logic            misalign;
    logic [2:0]      lane;
    logic [63:0]     mem_q [DEPTH];

    dmem_byte_mask u_byte_mask (
        .size    (req_size),
        .offset  (req_addr[2:0]),
        .byte_en (be),
        .misalign(misalign)
    );

    assign lane = spl_lane(req_size, req_addr[2:0]);

    always_comb begin
        cmd_in       = '0;
        cmd_in.write = req_write;
        cmd_in.err   = (req_addr[63:3] >= 61'(DEPTH)) || misalign;
        cmd_in.be    = be;
        cmd_in.data  = req_wdata << {lane, 3'b000};
        cmd_in.idx   = req_addr[AW+2:3];
    end

    // With zero wait states the response is built from the live request.
    assign cmd_sel = (state_q == ST_IDLE) ? cmd_in : cmd_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        go_rsp      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_d       = cmd_in;
                    req_ready_d = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESPOND;
                        go_rsp  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESPOND;
                    go_rsp  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
        if (go_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cmd_sel.err;
            rsp_rdata_d = (!cmd_sel.write && !cmd_sel.err) ? mem_q[cmd_sel.idx] : 64'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage is not reset; an async reset drops state to IDLE so no commit follows.
    always_ff @(posedge clk) begin
        if (state_q == ST_RESPOND && cmd_q.write && !cmd_q.err) begin
            for (int i = 0; i < BE_W; i++) begin
                if (cmd_q.be[i]) begin
                    mem_q[cmd_q.idx][8*i +: 8] <= cmd_q.data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
